// File: rtl/xdma_pkg.sv
// Shared XDMA types and constants: request / AW / W descriptors, address,
// length and id types, and the AXI constants used by the burst splitter.
package xdma_pkg;

  localparam int unsigned AddrWidth      = 48;
  localparam int unsigned DMALengthWidth = 32;
  localparam int unsigned IdWidth        = 8;

  // One AXI data beat carries 64 bytes; bursts are always INCR.
  localparam int unsigned AxiBeatBytes = 64;
  localparam logic [1:0]  AxiBurstIncr = 2'b01;
  localparam logic [2:0]  AxiSize64B   = 3'd6;
  localparam logic [3:0]  AxiCacheMod  = 4'b0011;

  typedef logic [AddrWidth-1:0]      addr_t;
  typedef logic [DMALengthWidth-1:0] len_t;
  typedef logic [IdWidth-1:0]        id_t;

  // Beats in one burst: 1..256, so nine bits.
  typedef logic [8:0] beats_t;

  // remote_addr is in bytes, dma_length is in 64-byte beats.
  typedef struct packed {
    id_t   dma_id;
    addr_t remote_addr;
    len_t  dma_length;
  } xdma_req_desc_t;

  typedef struct packed {
    id_t        id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [3:0] cache;
  } xdma_req_aw_desc_t;

  typedef struct packed {
    logic [7:0] num_beats;
    logic       is_single;
    logic       is_write_data;
  } xdma_req_w_desc_t;

endpackage

// File: rtl/xdma_burst_len_calc.sv
// Combinational beat count for the next burst: the smallest of the beats
// still to send, the burst cap, and the beats left before the next address
// boundary. The address is assumed 64-byte aligned.
module xdma_burst_len_calc
  import xdma_pkg::*;
#(
  parameter int unsigned MaxBurstBeats = 64,
  parameter int unsigned BoundaryBytes = 4096
) (
  input  addr_t  addr,
  input  len_t   remaining,
  output beats_t beats
);

  localparam int unsigned BndBits   = $clog2(BoundaryBytes);
  localparam int unsigned BeatShift = $clog2(AxiBeatBytes);
  localparam logic [31:0] MaxBeats  = 32'(MaxBurstBeats);

  logic [31:0] bnd_off;
  logic [31:0] bnd_beats;
  logic [31:0] cap;

  // Clamp the burst to the boundary, the burst cap and the remaining length.
  always_comb begin
    bnd_off   = 32'(addr[BndBits-1:0]);
    bnd_beats = (32'(BoundaryBytes) - bnd_off) >> BeatShift;
    cap       = (bnd_beats < MaxBeats) ? bnd_beats : MaxBeats;
    beats     = (remaining < cap) ? 9'(remaining) : 9'(cap);
  end

endmodule

// File: rtl/xdma_burst_splitter.sv
// Splits one XDMA write request into AXI bursts that never exceed
// MaxBurstBeats and never cross a BoundaryBytes address boundary. Each burst
// is offered as an AW descriptor and a W descriptor; the two streams
// handshake independently and the next burst is issued once both have.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both 1. Valid never depends on ready, and while valid is high
// and not yet accepted the descriptor is held stable. After a stream has
// accepted the current burst its valid stays low until the next burst.
//
// Optional: define XDMA_BURST_SPLITTER_PERF_CNT_EN to add burst_cnt_o, a
// wrapping 32-bit count of completed bursts.
module xdma_burst_splitter
  import xdma_pkg::*;
#(
  parameter int unsigned MaxBurstBeats = 64,
  parameter int unsigned BoundaryBytes = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  xdma_req_desc_t    desc_i,
  input  logic              desc_valid_i,
  output logic              desc_ready_o,
  output xdma_req_aw_desc_t aw_desc_o,
  output logic              aw_valid_o,
  input  logic              aw_ready_i,
  output xdma_req_w_desc_t  w_desc_o,
  output logic              w_valid_o,
  input  logic              w_ready_i,
  output logic              busy_o,
  output logic              done_o
`ifdef XDMA_BURST_SPLITTER_PERF_CNT_EN
  ,
  output logic [31:0]       burst_cnt_o
`endif
);

  localparam logic [0:0] StIdle  = 1'b0;
  localparam logic [0:0] StIssue = 1'b1;

  localparam int unsigned BeatShift = $clog2(AxiBeatBytes);

  logic [0:0] state;
  id_t        cur_id;
  addr_t      cur_addr;
  len_t       remaining;
  logic       aw_done;
  logic       w_done;
  beats_t     beats;

  logic       in_issue;
  logic       aw_hs;
  logic       w_hs;
  logic       burst_fin;
  logic       last_burst;

  xdma_burst_len_calc #(
    .MaxBurstBeats (MaxBurstBeats),
    .BoundaryBytes (BoundaryBytes)
  ) u_len_calc (
    .addr      (cur_addr),
    .remaining (remaining),
    .beats     (beats)
  );

  // Handshake decode and descriptor build; all outputs come from registers
  // so they stay stable while a burst waits for its consumers.
  always_comb begin
    in_issue     = (state == StIssue);
    desc_ready_o = (state == StIdle);
    busy_o       = in_issue;
    aw_valid_o   = in_issue && !aw_done;
    w_valid_o    = in_issue && !w_done;
    aw_hs        = aw_valid_o && aw_ready_i;
    w_hs         = w_valid_o && w_ready_i;
    burst_fin    = in_issue && (aw_done || aw_hs) && (w_done || w_hs);
    last_burst   = (remaining == len_t'(beats));

    aw_desc_o       = '0;
    aw_desc_o.id    = cur_id;
    aw_desc_o.addr  = cur_addr;
    aw_desc_o.len   = 8'(beats - 9'd1);
    aw_desc_o.size  = AxiSize64B;
    aw_desc_o.burst = AxiBurstIncr;
    aw_desc_o.cache = AxiCacheMod;

    w_desc_o               = '0;
    w_desc_o.num_beats     = 8'(beats - 9'd1);
    w_desc_o.is_single     = (beats == 9'd1);
    w_desc_o.is_write_data = 1'b1;
  end

  // Request latch, burst sequencing and the done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= StIdle;
      cur_id    <= '0;
      cur_addr  <= '0;
      remaining <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (state == StIdle) begin
        if (desc_valid_i) begin
          cur_id    <= desc_i.dma_id;
          cur_addr  <= desc_i.remote_addr & ~addr_t'(AxiBeatBytes - 1);
          remaining <= desc_i.dma_length;
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
          // A zero-length request completes without issuing anything.
          if (desc_i.dma_length == '0) begin
            done_o <= 1'b1;
          end else begin
            state <= StIssue;
          end
        end
      end else begin
        if (burst_fin) begin
          // beats never exceeds remaining, so the subtraction cannot wrap.
          cur_addr  <= cur_addr + (addr_t'(beats) << BeatShift);
          remaining <= remaining - len_t'(beats);
          aw_done   <= 1'b0;
          w_done    <= 1'b0;
          if (last_burst) begin
            state  <= StIdle;
            done_o <= 1'b1;
          end
        end else begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
      end
    end
  end

`ifdef XDMA_BURST_SPLITTER_PERF_CNT_EN
  // Completed-burst counter, wraps naturally at 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      burst_cnt_o <= '0;
    end else if (burst_fin) begin
      burst_cnt_o <= burst_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xdma_burst_splitter.sv
// Directed bench for xdma_burst_splitter with default parameters
// (64-beat cap, 4 KB boundary).
module tb_xdma_burst_splitter;
  import xdma_pkg::*;

  logic              clk;
  logic              rst;
  xdma_req_desc_t    desc;
  logic              desc_valid;
  logic              desc_ready;
  xdma_req_aw_desc_t aw_desc;
  logic              aw_valid;
  logic              aw_ready;
  xdma_req_w_desc_t  w_desc;
  logic              w_valid;
  logic              w_ready;
  logic              busy;
  logic              done;
`ifdef XDMA_BURST_SPLITTER_PERF_CNT_EN
  logic [31:0]       burst_cnt;
`endif

  int total;
  int bad;

  // Observed bursts, captured mid-cycle when valid and ready are both high.
  logic [47:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [7:0]  w_nb_q[$];
  logic        w_single_q[$];
  int          done_cnt;
  logic        mon_en;

  // Expected burst list for the scoreboard-style checks.
  logic [47:0] exp_q[$];
  logic [7:0]  exp_len_q[$];

  xdma_burst_splitter dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .desc_i       (desc),
    .desc_valid_i (desc_valid),
    .desc_ready_o (desc_ready),
    .aw_desc_o    (aw_desc),
    .aw_valid_o   (aw_valid),
    .aw_ready_i   (aw_ready),
    .w_desc_o     (w_desc),
    .w_valid_o    (w_valid),
    .w_ready_i    (w_ready),
    .busy_o       (busy),
    .done_o       (done)
`ifdef XDMA_BURST_SPLITTER_PERF_CNT_EN
    ,
    .burst_cnt_o  (burst_cnt)
`endif
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Burst monitor on the falling edge, where all signals are settled.
  always @(negedge clk) begin
    if (mon_en) begin
      if (aw_valid && aw_ready) begin
        aw_addr_q.push_back(aw_desc.addr);
        aw_len_q.push_back(aw_desc.len);
      end
      if (w_valid && w_ready) begin
        w_nb_q.push_back(w_desc.num_beats);
        w_single_q.push_back(w_desc.is_single);
      end
      if (done) done_cnt++;
    end
  end

  // Advance to 2 time units after the next rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offer one request for a single cycle; the caller ensures IDLE.
  task automatic send_desc(input logic [7:0] id, input logic [47:0] addr, input logic [31:0] len);
    desc.dma_id      = id;
    desc.remote_addr = addr;
    desc.dma_length  = len;
    desc_valid       = 1'b1;
    step();
    desc_valid       = 1'b0;
  endtask

  // Send a request with both readies high and record bursts until done.
  task automatic run_req(input logic [7:0] id, input logic [47:0] addr, input logic [31:0] len,
                         input int max_cyc, output logic timed_out);
    aw_addr_q.delete();
    aw_len_q.delete();
    w_nb_q.delete();
    w_single_q.delete();
    done_cnt = 0;
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    mon_en   = 1'b1;
    send_desc(id, addr, len);
    for (int i = 0; i < max_cyc; i++) begin
      if (done_cnt != 0) break;
      step();
    end
    timed_out = (done_cnt == 0);
    step();
    step();
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    total++;
    if (aw_valid !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs got aw_v=%b w_v=%b busy=%b done=%b exp all 0", aw_valid, w_valid, busy, done);
    end
    total++;
    if (desc_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready got=%b exp=1", desc_ready);
    end
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_burst();
    xdma_req_aw_desc_t exp_aw;
    xdma_req_w_desc_t  exp_w;
    exp_aw = '{id: 8'h05, addr: 48'h1000, len: 8'd15, size: 3'd6, burst: 2'b01, cache: 4'b0011};
    exp_w  = '{num_beats: 8'd15, is_single: 1'b0, is_write_data: 1'b1};
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    send_desc(8'h05, 48'h1000, 32'd16);
    total++;
    if (aw_valid !== 1'b1 || w_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL single_latency got aw_v=%b w_v=%b busy=%b exp 1 1 1", aw_valid, w_valid, busy);
    end
    total++;
    if (aw_desc !== exp_aw) begin
      bad++;
      $display("FAIL single_aw_desc got=%h exp=%h", aw_desc, exp_aw);
    end
    total++;
    if (w_desc !== exp_w) begin
      bad++;
      $display("FAIL single_w_desc got=%h exp=%h", w_desc, exp_w);
    end
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || aw_valid !== 1'b0 || w_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_done got done=%b busy=%b aw_v=%b w_v=%b exp 1 0 0 0", done, busy, aw_valid, w_valid);
    end
    step();
    total++;
    if (done !== 1'b0 || desc_ready !== 1'b1) begin
      bad++;
      $display("FAIL single_done_pulse got done=%b ready=%b exp 0 1", done, desc_ready);
    end
  endtask

  task automatic test_boundary();
    logic to;
    run_req(8'h11, 48'h1F80, 32'd4, 40, to);
    total++;
    if (to !== 1'b0 || done_cnt != 1) begin
      bad++;
      $display("FAIL boundary_done got timeout=%b done_cnt=%0d exp 0 1", to, done_cnt);
    end
    total++;
    if (aw_addr_q.size() != 2 || w_nb_q.size() != 2) begin
      bad++;
      $display("FAIL boundary_count got aw=%0d w=%0d exp 2 2", aw_addr_q.size(), w_nb_q.size());
    end else begin
      total++;
      if (aw_addr_q[0] !== 48'h1F80 || aw_addr_q[1] !== 48'h2000) begin
        bad++;
        $display("FAIL boundary_addr got %h %h exp 1f80 2000", aw_addr_q[0], aw_addr_q[1]);
      end
      total++;
      if (aw_len_q[0] !== 8'd1 || aw_len_q[1] !== 8'd1 || w_nb_q[0] !== 8'd1 || w_nb_q[1] !== 8'd1) begin
        bad++;
        $display("FAIL boundary_len got aw %0d %0d w %0d %0d exp all 1",
                 aw_len_q[0], aw_len_q[1], w_nb_q[0], w_nb_q[1]);
      end
    end
  endtask

  task automatic test_max_split();
    logic to;
`ifdef XDMA_BURST_SPLITTER_PERF_CNT_EN
    logic [31:0] cnt0;
    cnt0 = burst_cnt;
`endif
    exp_q.delete();
    exp_len_q.delete();
    exp_q.push_back(48'h0000); exp_len_q.push_back(8'd63);
    exp_q.push_back(48'h1000); exp_len_q.push_back(8'd63);
    exp_q.push_back(48'h2000); exp_len_q.push_back(8'd63);
    exp_q.push_back(48'h3000); exp_len_q.push_back(8'd7);
    run_req(8'h22, 48'h0, 32'd200, 60, to);
    total++;
    if (to !== 1'b0 || done_cnt != 1 || aw_addr_q.size() != 4 || w_nb_q.size() != 4) begin
      bad++;
      $display("FAIL split_count got timeout=%b done_cnt=%0d aw=%0d w=%0d exp 0 1 4 4",
               to, done_cnt, aw_addr_q.size(), w_nb_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < aw_addr_q.size() && i < w_nb_q.size()) begin
        total++;
        if (aw_addr_q[i] !== exp_q[i] || aw_len_q[i] !== exp_len_q[i] || w_nb_q[i] !== exp_len_q[i]) begin
          bad++;
          $display("FAIL split_burst%0d got addr=%h len=%0d nb=%0d exp addr=%h len=%0d",
                   i, aw_addr_q[i], aw_len_q[i], w_nb_q[i], exp_q[i], exp_len_q[i]);
        end
      end
    end
`ifdef XDMA_BURST_SPLITTER_PERF_CNT_EN
    total++;
    if (burst_cnt !== cnt0 + 32'd4) begin
      bad++;
      $display("FAIL split_burst_cnt got=%0d exp=%0d", burst_cnt, cnt0 + 32'd4);
    end
`endif
  endtask

  task automatic test_len_one();
    logic to;
    run_req(8'h33, 48'h2345, 32'd1, 20, to);
    total++;
    if (to !== 1'b0 || aw_addr_q.size() != 1 || w_single_q.size() != 1) begin
      bad++;
      $display("FAIL len1_count got timeout=%b aw=%0d w=%0d exp 0 1 1", to, aw_addr_q.size(), w_single_q.size());
    end else begin
      total++;
      if (aw_addr_q[0] !== 48'h2340 || aw_len_q[0] !== 8'd0 || w_single_q[0] !== 1'b1 || w_nb_q[0] !== 8'd0) begin
        bad++;
        $display("FAIL len1_fields got addr=%h len=%0d single=%b nb=%0d exp 2340 0 1 0",
                 aw_addr_q[0], aw_len_q[0], w_single_q[0], w_nb_q[0]);
      end
    end
  endtask

  task automatic test_len_zero();
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    send_desc(8'h44, 48'h5000, 32'd0);
    total++;
    if (done !== 1'b1 || aw_valid !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0 || desc_ready !== 1'b1) begin
      bad++;
      $display("FAIL len0 got done=%b aw_v=%b w_v=%b busy=%b ready=%b exp 1 0 0 0 1",
               done, aw_valid, w_valid, busy, desc_ready);
    end
    step();
    total++;
    if (done !== 1'b0 || aw_valid !== 1'b0) begin
      bad++;
      $display("FAIL len0_after got done=%b aw_v=%b exp 0 0", done, aw_valid);
    end
  endtask

  task automatic test_w_stall();
    xdma_req_w_desc_t exp_w;
    exp_w = '{num_beats: 8'd7, is_single: 1'b0, is_write_data: 1'b1};
    aw_ready = 1'b1;
    w_ready  = 1'b0;
    send_desc(8'h55, 48'h40, 32'd8);
    total++;
    if (aw_valid !== 1'b1 || w_valid !== 1'b1) begin
      bad++;
      $display("FAIL stall_start got aw_v=%b w_v=%b exp 1 1", aw_valid, w_valid);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      total++;
      if (aw_valid !== 1'b0 || w_valid !== 1'b1 || w_desc !== exp_w || aw_desc.addr !== 48'h40 || done !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d got aw_v=%b w_v=%b w=%h addr=%h done=%b exp 0 1 %h 40 0",
                 i, aw_valid, w_valid, w_desc, aw_desc.addr, done, exp_w);
      end
    end
    step();
    w_ready = 1'b1;
    step();
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || w_valid !== 1'b0) begin
      bad++;
      $display("FAIL stall_release got done=%b busy=%b w_v=%b exp 1 0 0", done, busy, w_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
`ifdef XDMA_BURST_SPLITTER_PERF_CNT_EN
    logic [31:0] cnt0;
    cnt0 = burst_cnt;
`endif
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    send_desc(8'h66, 48'h0, 32'd200);
    step();
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    total++;
    if (aw_valid !== 1'b1 || aw_desc.addr !== 48'h1000) begin
      bad++;
      $display("FAIL mid_second_burst got aw_v=%b addr=%h exp 1 1000", aw_valid, aw_desc.addr);
    end
`ifdef XDMA_BURST_SPLITTER_PERF_CNT_EN
    total++;
    if (burst_cnt !== cnt0 + 32'd1) begin
      bad++;
      $display("FAIL mid_cnt_before got=%0d exp=%0d", burst_cnt, cnt0 + 32'd1);
    end
`endif
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (aw_valid !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_async got aw_v=%b w_v=%b busy=%b done=%b exp all 0", aw_valid, w_valid, busy, done);
    end
`ifdef XDMA_BURST_SPLITTER_PERF_CNT_EN
    total++;
    if (burst_cnt !== 32'd0) begin
      bad++;
      $display("FAIL mid_cnt_reset got=%0d exp=0", burst_cnt);
    end
`endif
    step();
    rst      = 1'b0;
    aw_ready = 1'b1;
    w_ready  = 1'b1;
    total++;
    if (aw_desc.addr !== 48'h0 || aw_desc.id !== 8'h0) begin
      bad++;
      $display("FAIL mid_fields got addr=%h id=%h exp 0 0", aw_desc.addr, aw_desc.id);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (aw_valid !== 1'b0 || w_valid !== 1'b0 || busy !== 1'b0 || desc_ready !== 1'b1 || done !== 1'b0) begin
        bad++;
        $display("FAIL mid_after%0d got aw_v=%b w_v=%b busy=%b ready=%b done=%b exp 0 0 0 1 0",
                 i, aw_valid, w_valid, busy, desc_ready, done);
      end
    end
  endtask

  // Main sequence
  initial begin
    total      = 0;
    bad        = 0;
    done_cnt   = 0;
    mon_en     = 1'b0;
    desc       = '0;
    desc_valid = 1'b0;
    aw_ready   = 1'b1;
    w_ready    = 1'b1;
    rst        = 1'b1;
    test_reset();
    test_single_burst();
    test_boundary();
    test_max_split();
    test_len_one();
    test_len_zero();
    test_w_stall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xdma_burst_splitter.md
XDMA_BURST_SPLITTER -- requirements
Module: xdma_burst_splitter

Interface
REQ-001 Parameters SHALL be:
  - MaxBurstBeats, default 64, maximum beats per burst; power of two, 1..256.
  - BoundaryBytes, default 4096, address boundary that no burst may cross.
REQ-002 Ports SHALL be:
  - clk_i  in  1  clock.
  - rst_i  in  1  reset; one clock, reset is asynchronous and active-high.
  - desc_i  in  xdma_req_desc_t  transfer request; remote_addr in bytes, dma_length in 64-byte beats.
  - desc_valid_i  in  1  request valid.
  - desc_ready_o  out  1  request accepted.
  - aw_desc_o  out  xdma_req_aw_desc_t  per-burst AW descriptor.
  - aw_valid_o  out  1  AW descriptor valid.
  - aw_ready_i  in  1  AW consumer ready.
  - w_desc_o  out  xdma_req_w_desc_t  per-burst W descriptor.
  - w_valid_o  out  1  W descriptor valid.
  - w_ready_i  in  1  W consumer ready.
  - busy_o  out  1  request in progress.
  - done_o  out  1  one-cycle pulse when the last burst of a request has been accepted on both streams.

Function
REQ-003 The FSM SHALL have two states, IDLE and ISSUE.
REQ-004 desc_ready_o SHALL be 1 only in IDLE.
REQ-005 On a handshake in IDLE, the block SHALL latch dma_id, remote_addr with bits [5:0] forced to 0, and dma_length.
REQ-006 After a handshake with a nonzero length, the block SHALL enter ISSUE with aw_valid_o=w_valid_o=1 in the following cycle (latency 1).
REQ-007 A handshake with dma_length==0 SHALL stay in IDLE, emit no burst, and pulse done_o in the next cycle.
REQ-008 Burst beats SHALL be min(remaining, MaxBurstBeats, (BoundaryBytes - (addr mod BoundaryBytes))/64).
REQ-009 AW fields SHALL be: id=dma_id, addr=current address, len=beats-1, size=3'd6, burst=2'b01 (INCR), cache=4'b0011.
REQ-010 W fields SHALL be: num_beats=beats-1, is_single=(beats==1), is_write_data=1.
REQ-011 The AW and W streams SHALL handshake independently, with per-stream done flags.
REQ-012 Once a stream has handshaken for the current burst, its valid SHALL drop until the next burst.
REQ-013 The block SHALL advance to the next burst in the cycle after both streams have handshaken, or on the same cycle if both handshake together.
REQ-014 On advance: address += beats*64 and remaining -= beats.
REQ-015 When remaining reaches 0, the FSM SHALL return to IDLE and pulse done_o.
REQ-016 While valid and not yet handshaken, the descriptor outputs SHALL be held stable (AXI-style, no retraction).
REQ-017 busy_o SHALL equal (state==ISSUE).
REQ-018 Address arithmetic SHALL be AddrWidth bits, wrapping modulo 2^48. The remaining counter SHALL be DMALengthWidth bits and never underflow.

Reset
REQ-019 Asserting rst_i SHALL immediately force IDLE, with all valids, done_o and busy_o at 0 and all latched fields at 0.
REQ-020 Reset asserted mid-request SHALL abandon the request and emit no further bursts.

Configuration
REQ-021 With XDMA_BURST_SPLITTER_PERF_CNT_EN defined, the block SHALL add the output port burst_cnt_o (32 bits).
REQ-022 burst_cnt_o SHALL count completed bursts, wrap at 2^32, and reset to 0.
REQ-023 Without XDMA_BURST_SPLITTER_PERF_CNT_EN, the port and counter SHALL be absent, with identical behaviour otherwise.

Structure
REQ-024 xdma_req_desc_t, xdma_req_aw_desc_t, xdma_req_w_desc_t, addr_t, len_t and id_t SHALL come from xdma_pkg.
REQ-025 The new constants AxiBeatBytes=64 and AxiBurstIncr=2'b01 SHALL be added to xdma_pkg.
REQ-026 The beats computation SHALL be a combinational sub-module, xdma_burst_len_calc (inputs addr and remaining; output beats).
REQ-027 Everything else SHALL be flat.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
  - addr=0x1000, len=16, both readies=1 -> one burst: AW len=15, addr 0x1000; W num_beats=15; done_o one cycle after the AW/W handshake.
  - addr=0x1F80, len=4 -> bursts {addr 0x1F80, len=1} then {addr 0x2000, len=1}; no 4KB crossing.
  - addr=0x0, len=200, MaxBurstBeats=64 -> four bursts of len 63,63,63,7, at addrs 0x0,0x1000,0x2000,0x3000.
  - len=1 -> is_single=1, AW len=0; len=0 -> no valids, done_o pulse, desc_ready_o back to 1.
  - aw_ready_i=1 with w_ready_i=0 for 5 cycles -> aw_valid_o drops after its handshake, w_valid_o held stable, no advance until W handshakes.
  - rst_i pulsed during the 2nd of 4 bursts -> outputs 0 asynchronously; after release desc_ready_o=1 and burst_cnt_o=0 (macro on).
